// File: rtl/mul_addtree_pipe.sv
// rtl/mul_addtree_pipe.sv - pipelined add-tree multiplier, optional signed mode via MUL_ADDTREE_SIGNED_EN
module mul_addtree_pipe #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mul_a,
    input  logic [WIDTH-1:0]   mul_b,
`ifdef MUL_ADDTREE_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int LVL = $clog2(WIDTH);
    localparam int LAT = 1 + LVL;
    localparam int PW  = 2 * WIDTH;

    // tree[l] holds WIDTH>>l live entries; the upper slots of deeper levels stay zero.
    logic [PW-1:0]  tree [0:LVL][0:WIDTH-1];
    logic [LAT-1:0] vld;
    logic [PW-1:0]  pp_next [0:WIDTH-1];
    logic [PW-1:0]  a_ext;
    logic           stall;

    assign stall     = vld[LAT-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld[LAT-1];
    assign product   = tree[LVL][0];

    always_comb begin
`ifdef MUL_ADDTREE_SIGNED_EN
        a_ext = in_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
`else
        a_ext = {{WIDTH{1'b0}}, mul_a};
`endif
        for (int i = 0; i < WIDTH; i++) begin
            pp_next[i] = mul_b[i] ? (a_ext << i) : '0;
`ifdef MUL_ADDTREE_SIGNED_EN
            // Sign bit of the multiplier carries weight -2^(WIDTH-1).
            if (in_signed && (i == WIDTH - 1)) begin
                pp_next[i] = -(mul_b[i] ? (a_ext << i) : '0);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int l = 0; l <= LVL; l++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    tree[l][j] <= '0;
                end
            end
        end else if (!stall) begin
            vld <= {vld[LAT-2:0], in_valid};
            if (in_valid) begin
                for (int i = 0; i < WIDTH; i++) begin
                    tree[0][i] <= pp_next[i];
                end
            end
            for (int l = 1; l <= LVL; l++) begin
                for (int j = 0; j < WIDTH / 2; j++) begin
                    if (j < (WIDTH >> l)) begin
                        tree[l][j] <= tree[l-1][2*j] + tree[l-1][2*j+1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_addtree_pipe.sv
// tb/tb_mul_addtree_pipe.sv - scoreboard bench for mul_addtree_pipe, WIDTH=4
module tb_mul_addtree_pipe;

    localparam int W   = 4;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] mul_a = '0;
    logic [W-1:0] mul_b = '0;
`ifdef MUL_ADDTREE_SIGNED_EN
    logic         in_signed = 1'b0;
`endif
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] product;

    int             n_chk = 0;
    int             n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    bit             rnd_rdy = 1'b0;

    mul_addtree_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
`ifdef MUL_ADDTREE_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] e, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        mul_a = a;
        mul_b = b;
`ifdef MUL_ADDTREE_SIGNED_EN
        in_signed = s;
`else
        if (s) check("signed_unsupported", 0, 1);
`endif
        in_valid = 1'b1;
        while (!acc && waits < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (acc) exp_q.push_back(e);
        else check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops on every transfer and checks that a stalled result is held.
    logic [2*W-1:0] prev_prod;
    bit             prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_product", product, prev_prod);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                else check("product", product, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = product;
        end
    end

    initial begin
        int w;
        int k;
        int gaps;
        int tot;
        int stale;
        logic [2*W-1:0] e;

        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_product", product, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single operation and latency
        send(4'd15, 4'd15, 1'b0, 8'hE1, w);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        check("latency", k, LAT);
        @(negedge clk);
        check("single_valid_drop", out_valid, 0);
        drain();

        // streaming squares
        tot = 0;
        gaps = 0;
        fork
            begin
                for (int i = 1; i <= 9; i++) begin
                    send(W'(i), W'(i), 1'b0, 8'(i * i), w);
                    tot += w;
                end
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 20);
                check("stream_start", out_valid, 1);
                for (int i = 1; i < 9; i++) begin
                    @(negedge clk);
                    if (!out_valid) gaps++;
                end
            end
        join
        check("stream_in_ready_waits", tot, 0);
        check("stream_gaps", gaps, 0);
        drain();

        // backpressure
        fork
            begin
                send(4'd3, 4'd5, 1'b0, 8'd15, w);
                send(4'd7, 4'd7, 1'b0, 8'd49, w);
                send(4'd15, 4'd1, 1'b0, 8'd15, w);
                send(4'd2, 4'd3, 1'b0, 8'd6, w);
            end
            begin
                k = 0;
                while (!out_valid && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_product", product, 15);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // reset mid-flight
        send(4'd12, 4'd12, 1'b0, 8'd144, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_product", product, 0);
        check("midreset_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midreset_no_stale", stale, 0);
        @(posedge clk);
        #1;

`ifdef MUL_ADDTREE_SIGNED_EN
        send(4'h8, 4'h8, 1'b1, 8'h40, w);
        send(4'h8, 4'h7, 1'b1, 8'hC8, w);
        send(4'h7, 4'hF, 1'b1, 8'hF9, w);
        send(4'h8, 4'h8, 1'b0, 8'h40, w);
        send(4'h8, 4'h7, 1'b0, 8'h38, w);
        drain();
`endif

        // exhaustive unsigned with random gaps and backpressure
        rnd_rdy = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                e = 8'(a * b);
                send(W'(a), W'(b), 1'b0, e, w);
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_addtree_pipe.md
# mul_addtree_pipe

Parametrised, pipelined unsigned/signed array multiplier: WIDTH-bit operands, 2·WIDTH-bit product, partial products reduced by a registered binary adder tree. Accepts one operand pair per clock under a valid/ready handshake and stalls the entire pipeline on output backpressure. Sits between the tile's input pins (`ui_in`/`uio_in`) and `uo_out` as the arithmetic core, successor to the 4×4 combinational add-tree multiplier.

## Interface
- `WIDTH`, 4, operand width; power of two, 2..16.
- `LAT`, localparam = 1 + clog2(WIDTH), pipeline latency in cycles (3 for WIDTH=4).

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `mul_a`  in  WIDTH  multiplicand.
- `mul_b`  in  WIDTH  multiplier.
- `in_signed`  in  1  operands two's complement (only with `MUL_ADDTREE_SIGNED_EN`).
- `out_valid`  out  1  `product` holds a result.
- `out_ready`  in  1  downstream accepts result.
- `product`  out  2·WIDTH  mul_a × mul_b.

## Operation
- Stage 0 (PP): on accept, register WIDTH partial products pp[i] = mul_b[i] ? (mul_a << i) : 0, each 2·WIDTH bits, plus a valid bit.
- Stages 1..clog2(WIDTH): each level adds adjacent pairs of the previous level (pp0+pp1, pp2+pp3, …), halving the count; all sums 2·WIDTH bits, carries out of bit 2·WIDTH−1 discarded (cannot occur for unsigned).
- Final level output is `product`; its valid bit is `out_valid`.
- Each stage carries a valid bit; bubbles propagate as invalid entries, data in invalid stages is don't-care but must not reach `product` while `out_valid`=1.
- Stall = `out_valid` & ~`out_ready`. When stalled, all stage registers (data and valid) hold. When not stalled, every stage advances.
- `in_ready` = ~stall (combinational). Pair accepted when `in_valid` & `in_ready`; when `in_ready`=1 and `in_valid`=0 a bubble enters.
- No internal state machine beyond valid shift chain; throughput 1 result/cycle with `out_ready` held high.

## Timing
- Reset (async assert, sync deassert handled externally): all valid bits 0, all data registers 0; `out_valid`=0, `product`=0, `in_ready`=1 while in reset.
- Latency: pair accepted at edge k → `out_valid`=1 with result after edge k+LAT−1, i.e. visible in cycle k+LAT... stated precisely: accepted at rising edge n, `product` valid during cycle following edge n+LAT−1 (WIDTH=4: accepted at edge 0, valid after edge 2).
- Result held stable with `out_valid`=1 until the edge where `out_ready`=1.
- Simultaneous `out_ready` deassert and new `in_valid`: `in_ready`=0 that cycle, input not taken, upstream must hold.
- Stall with bubbles inside pipeline is not compressed: global stall, no bubble collapsing.
- Reset asserted mid-stream: all in-flight results discarded immediately, no partial output.
- `mul_a`/`mul_b`/`in_signed` sampled only on accepting edge; changes otherwise ignored.

## Configuration
- `MUL_ADDTREE_SIGNED_EN` defined: `in_signed` port present and piped with the data. When 1, operands are two's complement: partial products sign-extend mul_a to 2·WIDTH, and the MSB row (mul_b[WIDTH−1]) is subtracted (added as two's-complement negation) instead of added; product is exact 2·WIDTH-bit signed result. When 0, unsigned as below.
- Undefined: `in_signed` port absent, unsigned multiply only, no negation logic synthesised.

## Test plan
- Reset then single op, WIDTH=4, out_ready=1: mul_a=15, mul_b=15 → out_valid after LAT=3 edges, product=8'hE1 (225), then out_valid=0.
- Streaming: pairs (1,1),(2,2)…(9,9) on consecutive cycles → products 1,4,9,…,81 on consecutive cycles, no gaps, in_ready stays 1.
- Backpressure: stream (3,5),(7,7),(15,1), drop out_ready for 4 cycles after first out_valid → product=15 held, in_ready=0 during stall, then 49,15 in order, none lost/duplicated.
- Reset mid-flight: accept (12,12), assert rst_n=0 one cycle later → out_valid=0, product=0 immediately; after release no stale 144 emerges.
- Signed (macro on): in_signed=1, (−8,−8) → 8'h40; (−8,7) → 8'hC8; (7,−1) → 8'hF9; same pair with in_signed=0 (8,8) → 8'h40, (8,7) → 8'h38.
- Exhaustive WIDTH=4 and random WIDTH=8/16 with random in_valid/out_ready against reference model: all products match, order preserved.
